codificador_hamming: RTL
========================

// Module: codificador_hamming
// PURPOSE
//  Hamming(7,4) encoder stage that feeds Decodificador. Accepts 4-bit data words through a
//  valid/ready handshake and buffers them in a FIFO. Emits registered 7-bit codewords.
//  Optionally flips one codeword bit so the downstream decoder's single-error correction
//  can be exercised.
// PARAMETERS
//  PROFUNDIDADE   4   FIFO depth in words; must be a power of 2 and >= 2
//  LARG_CONTADOR  8   width of the sent-word counter
// PORTS
//  clk                input   1              rising-edge clock
//  Reset              input   1              async, active-high; clears all state
//  Dado               input   4              data word {d3,d2,d1,d0}
//  Dado_valido        input   1              upstream word present
//  Dado_pronto        output  1              block can accept a word (= !fifo_full)
//  Injetar_erro       input   1              enable single-bit error injection
//  Posicao_erro       input   3              codeword position 1..7 to flip; 0 = none
//  Saida              output  7              codeword
//  Saida_valida       output  1              Saida holds a valid codeword
//  Saida_pronta       input   1              downstream accepts Saida this cycle
//  Palavras_enviadas  output  LARG_CONTADOR  count of completed output handshakes
// BEHAVIOUR
//  - Reset (async, any time, including mid-transfer):
//    - FIFO emptied and pointers cleared; Dado_pronto=1 once Reset deasserts.
//    - Saida=0, Saida_valida=0, Palavras_enviadas=0.
//  - Codeword layout (position p = Saida[p-1]):
//    Saida = {d3,d2,d1,p4,d0,p2,p1}
//    p1 = d0^d1^d3;  p2 = d0^d2^d3;  p4 = d1^d2^d3
//  - Write: Dado_valido && Dado_pronto at a rising edge pushes Dado into the FIFO.
//    - Dado_pronto is combinational from FIFO occupancy only.
//    - When full, no write occurs, even if a pop happens in the same cycle.
//  - Output register (single stage):
//    - Loads from the FIFO head when FIFO is non-empty and (!Saida_valida || Saida_pronta).
//    - The load pops the head; Saida_valida=1 after that edge.
//    - If no load occurs and Saida_valida && Saida_pronta, Saida_valida clears at the edge.
//    - Saida holds its last value while invalid.
//  - Latency:
//    - Word accepted at edge N into an empty FIFO with a free output -> Saida_valida=1 after
//      edge N+1.
//    - Back-to-back sustained throughput is 1 word/cycle while Saida_pronta=1.
//  - Stall: while Saida_valida && !Saida_pronta, Saida and Saida_valida hold stable.
//    Inputs keep filling the FIFO until full.
//  - Error injection:
//    - Injetar_erro and Posicao_erro are sampled at the edge that loads the output register.
//    - If Injetar_erro=1 and Posicao_erro!=0, bit Saida[Posicao_erro-1] is inverted in the
//      loaded word.
//    - Posicao_erro=0 or Injetar_erro=0 loads the clean codeword.
//    - At most one bit is ever flipped.
//  - Palavras_enviadas increments by 1 on each edge with Saida_valida && Saida_pronta.
//    It wraps from 2^LARG_CONTADOR-1 to 0.
//  - FIFO pointers are log2(PROFUNDIDADE)+1 bits (wrap bit).
//    - full: addresses equal, wrap bits differ.  empty: pointers equal.
//    - Pointers wrap with no loss.
//  - Simultaneous push and pop with FIFO non-empty and not full: occupancy unchanged, order
//    preserved.
//  - Push into an empty FIFO while the output register is free: the word becomes visible the
//    following cycle. No same-cycle bypass.
// TESTING
//  1. Clean encoding.
//     Reset pulse, Saida_pronta=1. Send Dado=4'b1011 -> Saida=7'b1010101, Saida_valida=1
//     two edges after acceptance.
//     Send 4'b0000 -> 7'b0000000; 4'b1111 -> 7'b1111111; 4'b0001 -> 7'b0000111.
//  2. Injection.
//     Injetar_erro=1, Posicao_erro=3, Dado=4'b1011 -> Saida=7'b1010001.
//     Posicao_erro=0 -> 7'b1010101.
//     Feeding Saida into Decodificador returns 4'b1011 in both cases.
//  3. Backpressure / full.
//     Saida_pronta=0, push 1,2,3,4,5 continuously.
//     Required: first word sits in the output register; FIFO holds 2,3,4,5.
//     Dado_pronto=0 after the 5th accept, and a 6th word is not accepted.
//     Release Saida_pronta -> codewords for 1..5 emerge in order, one per cycle.
//  4. Counter wrap.
//     LARG_CONTADOR=3, stream 9 words with Saida_pronta=1 -> Palavras_enviadas=1.
//  5. Reset mid-operation.
//     FIFO holding 3 words and Saida_valida=1, assert Reset between edges.
//     Required: Saida_valida=0, Saida=0, Dado_pronto=1 and counter=0 immediately, without
//     waiting for a clock edge.
//     After release, no stale word is emitted.
//  6. Simultaneous push and pop at steady state.
//     Dado_valido=1 and Saida_pronta=1 for 20 cycles with incrementing data.
//     Required: one codeword per cycle, no drops or duplicates, Dado_pronto stays 1.

Source files
------------

// File: rtl/codificador_hamming_if.sv
// Handshake bundle between the Hamming(7,4) encoder and its neighbours:
// data-in side (producer), codeword-out side (consumer) and error-injection controls.
interface codificador_hamming_if #(
    parameter int LARG_CONTADOR = 8
);
    logic [3:0]               Dado;
    logic                     Dado_valido;
    logic                     Dado_pronto;
    logic                     Injetar_erro;
    logic [2:0]               Posicao_erro;
    logic [6:0]               Saida;
    logic                     Saida_valida;
    logic                     Saida_pronta;
    logic [LARG_CONTADOR-1:0] Palavras_enviadas;

    modport master (
        output Dado, Dado_valido, Injetar_erro, Posicao_erro, Saida_pronta,
        input  Dado_pronto, Saida, Saida_valida, Palavras_enviadas
    );

    modport slave (
        input  Dado, Dado_valido, Injetar_erro, Posicao_erro, Saida_pronta,
        output Dado_pronto, Saida, Saida_valida, Palavras_enviadas
    );
endinterface

// File: rtl/codificador_hamming.sv
// Hamming(7,4) encoder: 4-bit words enter a small FIFO, leave as registered 7-bit
// codewords with optional single-bit error injection for exercising the decoder.
module codificador_hamming #(
    parameter int PROFUNDIDADE  = 4,
    parameter int LARG_CONTADOR = 8
) (
    input  logic                 clk,
    input  logic                 Reset,
    codificador_hamming_if.slave bus
);
    localparam int AW = $clog2(PROFUNDIDADE);
    localparam logic [AW:0]              PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [LARG_CONTADOR-1:0] CNT_ONE = {{(LARG_CONTADOR-1){1'b0}}, 1'b1};

    logic [3:0]               mem [PROFUNDIDADE];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     fire;
    logic [3:0]               head_p0;
    logic [6:0]               code_p1;
    logic                     vld_p1;
    logic [LARG_CONTADOR-1:0] cnt;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Position 0 means "no flip", so a single-hot mask is built only for 1..7.
    function automatic logic [6:0] inject(input logic [6:0] code, input logic en,
                                          input logic [2:0] pos);
        logic [6:0] mask;
        mask = '0;
        if (en && (pos != 3'd0))
            mask[pos - 3'd1] = 1'b1;
        return code ^ mask;
    endfunction

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = bus.Dado_valido && !full;
    assign pop     = !empty && (!vld_p1 || bus.Saida_pronta);
    assign fire    = vld_p1 && bus.Saida_pronta;
    assign head_p0 = mem[rd_ptr[AW-1:0]];

    // Stage p0: FIFO storage; only the pointers carry reset state.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.Dado;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Stage p1: output codeword register and completed-handshake counter.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            code_p1 <= '0;
            vld_p1  <= 1'b0;
            cnt     <= '0;
        end else begin
            if (pop) begin
                code_p1 <= inject(encode(head_p0), bus.Injetar_erro, bus.Posicao_erro);
                vld_p1  <= 1'b1;
            end else if (fire) begin
                vld_p1  <= 1'b0;
            end
            if (fire)
                cnt <= cnt + CNT_ONE;
        end
    end

    assign bus.Dado_pronto       = !full;
    assign bus.Saida             = code_p1;
    assign bus.Saida_valida      = vld_p1;
    assign bus.Palavras_enviadas = cnt;
endmodule
